// File: rtl/herm_buff_stream.sv
// herm_buff_stream: Hermitian-symmetry framer between the constellation mapper
// and the IFFT. Buffers N_SYM*N_ACT complex symbols, then streams N_SYM frames
// of N_FFT bins: zero DC, data bins, zero padding, mirrored conjugates.
// Ports:
//   clk, rst (sync, active high), flush (sync burst abort)
//   din/din_valid/din_ready            : mapper input, accepted only while filling
//   dout/dout_valid/dout_ready         : IFFT input stream
//   dout_sym_last, dout_burst_last     : end of symbol / end of burst markers
//   busy                               : high while frames are being emitted
module herm_buff_stream #(
  parameter int unsigned DW       = 16,
  parameter int unsigned N_FFT    = 64,
  parameter int unsigned N_ACT    = 28,
  parameter int unsigned N_SYM    = 8,
  parameter int unsigned CONJ_SAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_sym_last,
  output logic          dout_burst_last,
  output logic          busy
);

  localparam int unsigned DEPTH = N_ACT * N_SYM;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NW    = $clog2(N_FFT);
  localparam int unsigned SW    = (N_SYM > 1) ? $clog2(N_SYM) : 1;
  localparam int unsigned HW    = DW / 2;

  typedef enum logic {ST_FILL, ST_EMIT} state_e;
  typedef enum logic [1:0] {K_ZERO, K_DATA, K_CONJ} kind_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
  logic            issue_q, issue_d;
  logic [SW-1:0]   sym_q, sym_d;
  logic [NW-1:0]   bin_q, bin_d;
  logic [AW-1:0]   base_q, base_d;
  logic            s1_v_q, s1_v_d;
  kind_e           s1_kind_q, s1_kind_d;
  logic            s1_sym_last_q, s1_sym_last_d;
  logic            s1_burst_last_q, s1_burst_last_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            dout_valid_q, dout_valid_d;
  logic            sym_last_q, sym_last_d;
  logic            burst_last_q, burst_last_d;

  logic [DW-1:0]   mem [DEPTH];
  logic [DW-1:0]   rd_data_q;
  logic [AW-1:0]   rd_addr;
  kind_e           kind_c;
  logic [DW-1:0]   out_c;
  logic            wr_en, rd_en, adv;

  function automatic logic [DW-1:0] conj_f(input logic [DW-1:0] x);
    logic [HW-1:0] q;
    logic [HW-1:0] nq;
    q  = x[DW-1:HW];
    nq = -q;
    if (CONJ_SAT != 0 && q == {1'b1, {(HW-1){1'b0}}})
      nq = {1'b0, {(HW-1){1'b1}}};
    return {nq, x[HW-1:0]};
  endfunction

  // Bin classification and buffer address for the bin being issued.
  always_comb begin
    kind_c  = K_ZERO;
    rd_addr = base_q;
    if (bin_q != '0 && 32'(bin_q) <= N_ACT) begin
      kind_c  = K_DATA;
      rd_addr = base_q + AW'(bin_q) - AW'(1);
    end else if (32'(bin_q) >= N_FFT - N_ACT) begin
      kind_c  = K_CONJ;
      rd_addr = base_q + AW'(NW'(N_FFT - 1) - bin_q);
    end
  end

  always_comb begin
    case (s1_kind_q)
      K_DATA:  out_c = rd_data_q;
      K_CONJ:  out_c = conj_f(rd_data_q);
      default: out_c = '0;
    endcase
  end

  // Issue -> RAM read -> output register; the whole pipe freezes on a stalled output.
  assign adv = !(dout_valid_q && !dout_ready);

  always_comb begin
    state_d         = state_q;
    wr_cnt_d        = wr_cnt_q;
    issue_d         = issue_q;
    sym_d           = sym_q;
    bin_d           = bin_q;
    base_d          = base_q;
    s1_v_d          = s1_v_q;
    s1_kind_d       = s1_kind_q;
    s1_sym_last_d   = s1_sym_last_q;
    s1_burst_last_d = s1_burst_last_q;
    dout_d          = dout_q;
    dout_valid_d    = dout_valid_q;
    sym_last_d      = sym_last_q;
    burst_last_d    = burst_last_q;
    wr_en           = 1'b0;
    rd_en           = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (din_valid) begin
          wr_en = 1'b1;
          if (wr_cnt_q == AW'(DEPTH - 1)) begin
            state_d  = ST_EMIT;
            wr_cnt_d = '0;
            issue_d  = 1'b1;
            sym_d    = '0;
            bin_d    = '0;
            base_d   = '0;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      ST_EMIT: begin
        if (adv) begin
          rd_en           = issue_q;
          s1_v_d          = issue_q;
          s1_kind_d       = kind_c;
          s1_sym_last_d   = issue_q && (bin_q == NW'(N_FFT - 1));
          s1_burst_last_d = issue_q && (bin_q == NW'(N_FFT - 1)) && (sym_q == SW'(N_SYM - 1));
          dout_valid_d    = s1_v_q;
          dout_d          = s1_v_q ? out_c : '0;
          sym_last_d      = s1_v_q && s1_sym_last_q;
          burst_last_d    = s1_v_q && s1_burst_last_q;
          if (issue_q) begin
            if (bin_q == NW'(N_FFT - 1)) begin
              bin_d  = '0;
              sym_d  = sym_q + 1'b1;
              base_d = base_q + AW'(N_ACT);
              if (sym_q == SW'(N_SYM - 1))
                issue_d = 1'b0;
            end else begin
              bin_d = bin_q + 1'b1;
            end
          end
        end
        if (dout_valid_q && dout_ready && burst_last_q) begin
          state_d      = ST_FILL;
          dout_valid_d = 1'b0;
          dout_d       = '0;
          sym_last_d   = 1'b0;
          burst_last_d = 1'b0;
        end
      end
      default: state_d = ST_FILL;
    endcase

    if (flush) begin
      state_d      = ST_FILL;
      wr_cnt_d     = '0;
      issue_d      = 1'b0;
      s1_v_d       = 1'b0;
      dout_valid_d = 1'b0;
      dout_d       = '0;
      sym_last_d   = 1'b0;
      burst_last_d = 1'b0;
      wr_en        = 1'b0;
      rd_en        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_cnt_q] <= din;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_FILL;
      wr_cnt_q        <= '0;
      issue_q         <= 1'b0;
      sym_q           <= '0;
      bin_q           <= '0;
      base_q          <= '0;
      s1_v_q          <= 1'b0;
      s1_kind_q       <= K_ZERO;
      s1_sym_last_q   <= 1'b0;
      s1_burst_last_q <= 1'b0;
      dout_q          <= '0;
      dout_valid_q    <= 1'b0;
      sym_last_q      <= 1'b0;
      burst_last_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_cnt_q        <= wr_cnt_d;
      issue_q         <= issue_d;
      sym_q           <= sym_d;
      bin_q           <= bin_d;
      base_q          <= base_d;
      s1_v_q          <= s1_v_d;
      s1_kind_q       <= s1_kind_d;
      s1_sym_last_q   <= s1_sym_last_d;
      s1_burst_last_q <= s1_burst_last_d;
      dout_q          <= dout_d;
      dout_valid_q    <= dout_valid_d;
      sym_last_q      <= sym_last_d;
      burst_last_q    <= burst_last_d;
    end
  end

  assign din_ready       = (state_q == ST_FILL);
  assign busy            = (state_q == ST_EMIT);
  assign dout            = dout_q;
  assign dout_valid      = dout_valid_q;
  assign dout_sym_last   = sym_last_q;
  assign dout_burst_last = burst_last_q;

endmodule

// File: tb/tb_herm_buff_stream.sv
// Directed bench for herm_buff_stream at DW=16, N_FFT=8, N_ACT=3, N_SYM=2.
// A second instance with CONJ_SAT=0 shares all inputs to cover the wrap case.
module tb_herm_buff_stream;

  logic        clk = 1'b0;
  logic        rst, flush, din_valid, dout_ready;
  logic [15:0] din;
  logic [15:0] dout, dout2;
  logic        din_ready, dout_valid, sym_last, burst_last, busy;
  logic        dr2, dv2, sl2, bl2, busy2;

  int checks   = 0;
  int failures = 0;

  logic [15:0] data_v [6];
  logic [15:0] exp1 [16];
  logic [15:0] exp2 [16];

  logic [15:0] basic_tab [16] = '{
    16'h0000, 16'h0101, 16'h0202, 16'h0303, 16'h0000, 16'hFD03, 16'hFE02, 16'hFF01,
    16'h0000, 16'h0404, 16'h0505, 16'h0606, 16'h0000, 16'hFA06, 16'hFB05, 16'hFC04};
  logic [15:0] sat1_tab [16] = '{
    16'h0000, 16'h8011, 16'h0202, 16'h0303, 16'h0000, 16'hFD03, 16'hFE02, 16'h7F11,
    16'h0000, 16'h0404, 16'h0505, 16'h8006, 16'h0000, 16'h7F06, 16'hFB05, 16'hFC04};
  logic [15:0] sat0_tab [16] = '{
    16'h0000, 16'h8011, 16'h0202, 16'h0303, 16'h0000, 16'hFD03, 16'hFE02, 16'h8011,
    16'h0000, 16'h0404, 16'h0505, 16'h8006, 16'h0000, 16'h8006, 16'hFB05, 16'hFC04};

  herm_buff_stream #(.DW(16), .N_FFT(8), .N_ACT(3), .N_SYM(2), .CONJ_SAT(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_sym_last(sym_last), .dout_burst_last(burst_last), .busy(busy));

  herm_buff_stream #(.DW(16), .N_FFT(8), .N_ACT(3), .N_SYM(2), .CONJ_SAT(0)) dut_wrap (
    .clk(clk), .rst(rst), .flush(flush), .din(din), .din_valid(din_valid),
    .din_ready(dr2), .dout(dout2), .dout_valid(dv2), .dout_ready(dout_ready),
    .dout_sym_last(sl2), .dout_burst_last(bl2), .busy(busy2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference frame: DC zero, data bins, zero pad, conjugate mirror.
  function automatic logic [15:0] ref_s(input int k, input bit sat);
    int s, n;
    logic [7:0]  q;
    logic [15:0] x;
    s = k / 8;
    n = k % 8;
    if (n == 0) return 16'h0000;
    if (n <= 3) return data_v[s*3 + n - 1];
    if (n < 5)  return 16'h0000;
    x = data_v[s*3 + 7 - n];
    q = x[15:8];
    if (q == 8'h80) q = sat ? 8'h7F : 8'h80;
    else            q = -q;
    return {q, x[7:0]};
  endfunction

  task automatic build_exp;
    for (int k = 0; k < 16; k++) begin
      exp1[k] = ref_s(k, 1'b1);
      exp2[k] = ref_s(k, 1'b0);
    end
  endtask

  task automatic send(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        din_valid = 1'b0;
        din       = 16'hDEAD;
        tick;
      end
      din       = data_v[i];
      din_valid = 1'b1;
      tick;
    end
    din_valid = 1'b0;
  endtask

  // Returns with the nstop-th handshake pending on the next edge.
  task automatic collect(input bit rnd, input int nstop, input string tag);
    int k = 0;
    int cyc = 0;
    int first = -1;
    int firsths = -1;
    int lasths = -1;
    bit stalled = 1'b0;
    bit armed = 1'b0;
    bit r;
    logic [15:0] pd;
    logic pl, pb;
    while (k < nstop && cyc < 300) begin
      if (stalled) begin
        chk({tag, "_hold_valid"}, dout_valid, 1);
        chk({tag, "_hold_data"}, dout, pd);
        chk({tag, "_hold_flags"}, {sym_last, burst_last}, {pl, pb});
      end
      if (dout_valid && first < 0) first = cyc;
      r = !rnd ? 1'b1 : (armed ? 1'($urandom_range(0, 1)) : 1'b0);
      if (dout_valid) armed = 1'b1;
      dout_ready = r;
      stalled = dout_valid && !r;
      pd = dout;
      pl = sym_last;
      pb = burst_last;
      if (dout_valid && r) begin
        chk({tag, "_data"}, dout, exp1[k]);
        chk({tag, "_wrap_data"}, {dv2, dout2}, {1'b1, exp2[k]});
        chk({tag, "_sym_last"}, sym_last, (k % 8 == 7));
        chk({tag, "_burst_last"}, burst_last, (k == 15));
        if (firsths < 0) firsths = cyc;
        lasths = cyc;
        k++;
        if (k == nstop) break;
      end
      tick;
      cyc++;
    end
    chk({tag, "_count"}, k, nstop);
    chk({tag, "_latency"}, (first >= 0 && first <= 2), 1);
    if (!rnd && nstop == 16) chk({tag, "_no_bubble"}, lasths - firsths, 15);
  endtask

  task automatic post_burst(input string tag);
    chk({tag, "_post_valid"}, dout_valid, 0);
    chk({tag, "_post_flags"}, {sym_last, burst_last}, 2'b00);
    chk({tag, "_post_ready"}, din_ready, 1);
    chk({tag, "_post_busy"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; din_valid = 1'b0; din = '0; dout_ready = 1'b0;
    repeat (3) tick;
    rst = 1'b0;
    chk("rst_dout", dout, 16'h0000);
    chk("rst_valid", {dout_valid, dv2}, 2'b00);
    chk("rst_flags", {sym_last, burst_last, sl2, bl2}, 4'b0000);
    chk("rst_busy", {busy, busy2}, 2'b00);
    chk("rst_din_ready", {din_ready, dr2}, 2'b11);

    // Basic burst, ready held high.
    data_v = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606};
    exp1 = basic_tab;
    exp2 = basic_tab;
    send(6, 1'b0);
    chk("fill_done_ready", din_ready, 0);
    chk("fill_done_busy", busy, 1);
    collect(1'b0, 16, "basic");
    tick;
    post_burst("basic");

    // Back-to-back burst under random backpressure.
    send(6, 1'b0);
    collect(1'b1, 16, "bp");
    tick;
    post_burst("bp");

    // Saturating vs wrapping conjugate of 0x80 imaginary.
    data_v = '{16'h8011, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h8006};
    exp1 = sat1_tab;
    exp2 = sat0_tab;
    send(6, 1'b0);
    collect(1'b1, 16, "sat");
    tick;
    post_burst("sat");

    // Gapped input, then din_valid held with junk during emission.
    data_v = '{16'h1122, 16'h3344, 16'h5566, 16'h778A, 16'h99BC, 16'hDEF0};
    build_exp;
    send(6, 1'b1);
    din_valid = 1'b1;
    din = 16'hBEEF;
    chk("hold_din_ready", din_ready, 0);
    collect(1'b0, 16, "gap");
    tick;
    din_valid = 1'b0;
    post_burst("gap");

    // Flush after 4 inputs, with a simultaneous din handshake that must be dropped.
    data_v = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE, 16'h9999};
    send(4, 1'b0);
    flush = 1'b1;
    din_valid = 1'b1;
    din = 16'h5A5A;
    tick;
    flush = 1'b0;
    din_valid = 1'b0;
    chk("flush_fill_ready", din_ready, 1);
    chk("flush_fill_busy", busy, 0);
    chk("flush_fill_valid", dout_valid, 0);
    data_v = '{16'h0F01, 16'h0E02, 16'h0D03, 16'h0C04, 16'h0B05, 16'h0A06};
    build_exp;
    send(6, 1'b0);
    collect(1'b0, 16, "flush_fill");
    tick;
    post_burst("flush_fill");

    // Flush while sample 5 is presented and ready is high.
    send(6, 1'b0);
    collect(1'b0, 5, "flush_emit");
    tick;
    chk("flush_emit_s5_valid", dout_valid, 1);
    chk("flush_emit_s5_data", dout, exp1[5]);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    post_burst("flush_emit");

    // Reset mid-emission.
    send(6, 1'b0);
    collect(1'b0, 3, "rst_emit");
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_emit_dout", dout, 16'h0000);
    post_burst("rst_emit");

    // Clean burst after reset.
    data_v = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606};
    exp1 = basic_tab;
    exp2 = basic_tab;
    send(6, 1'b0);
    collect(1'b0, 16, "post_rst");
    tick;
    post_burst("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/herm_buff_stream.md
Name: herm_buff_stream

Overview:
Parametrised Hermitian-symmetry framer for the OFDM transmit path, placed between the constellation mapper and the IFFT. Collects N_SYM×N_ACT complex symbols, then streams N_SYM IFFT input frames of N_FFT samples each under valid/ready handshake. Each frame carries a zero DC bin, data bins, zero padding and the mirrored conjugates, so the IFFT output is real.
Conjugation is computed on the fly with saturation, so only one data buffer is needed.

Parameters:
DW, 16, complex sample width; upper DW/2 bits = imaginary (Q), lower DW/2 = real (I), two's complement
N_FFT, 64, IFFT points per symbol
N_ACT, 28, active data subcarriers per symbol; legal iff 2*N_ACT+1 <= N_FFT
N_SYM, 8, OFDM symbols per burst
CONJ_SAT, 1, 1 = saturate negation of -2^(DW/2-1) to 2^(DW/2-1)-1; 0 = wrap

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  synchronous abort of current burst (tx_done equivalent)
din  in  DW  mapper sample
din_valid  in  1  din qualifier
din_ready  out  1  block accepts din
dout  out  DW  IFFT input sample
dout_valid  out  1  dout qualifier
dout_ready  in  1  downstream accepts dout
dout_sym_last  out  1  high with last sample (bin N_FFT-1) of each symbol
dout_burst_last  out  1  high with last sample of last symbol
busy  out  1  high while in EMIT

Behaviour:
- Reset: FSM = FILL, write count 0, din_ready=1 on the cycle after rst deasserts, dout=0, dout_valid=0, both last flags 0, busy=0.
- Buffer: single RAM, depth N_ACT*N_SYM, width DW. Counters are $clog2 sized.
- FILL: if din_valid && din_ready, write din at wr_cnt and increment wr_cnt. The handshake that writes entry N_ACT*N_SYM-1 moves the FSM to EMIT on the next edge. din_ready=0 from that edge on.
- EMIT: sym index s, bin n (0..N_FFT-1). Output sample for (s,n):
  - n=0: 0
  - 1<=n<=N_ACT: X[s*N_ACT+n-1]
  - N_ACT<n<N_FFT-N_ACT: 0
  - n>=N_FFT-N_ACT: conj(X[s*N_ACT+N_FFT-1-n])
- conj: negate the upper DW/2 bits and pass the lower half unchanged. Saturation applies per CONJ_SAT.
- Latency: first dout_valid no later than 2 cycles after entering EMIT (synchronous RAM read plus output register).
- Output handshake: a sample advances only on dout_valid && dout_ready. While dout_ready=0, dout, dout_valid and the flags hold stable. With dout_ready held high, one sample per cycle, no bubbles inside or between symbols.
- After the dout_burst_last handshake: dout_valid=0 next edge, FSM returns to FILL with wr_cnt=0, din_ready=1 on that edge.
- No overlap: din_ready=0 for the whole of EMIT. din_valid in EMIT is ignored and not stored.
- flush (any state): next edge FSM=FILL, wr_cnt=0, dout_valid=0, flags 0, busy=0. Partially written data is discarded. flush has priority over a simultaneous din or dout handshake in the same cycle.
- rst has priority over flush and behaves identically mid-burst, plus the FSM is forced to FILL.
- busy=1 exactly while FSM=EMIT.

Test Plan:
Configuration DW=16, N_FFT=8, N_ACT=3, N_SYM=2.
- Basic burst: input 0x0101,0x0202,0x0303,0x0404,0x0505,0x0606, dout_ready=1 -> 16 samples.
  - Symbol 0: 0000,0101,0202,0303,0000,FD03,FE02,FF01
  - Symbol 1: 0000,0404,0505,0606,0000,FA06,FB05,FC04
  - dout_sym_last on samples 7 and 15; dout_burst_last on 15 only.
- Saturation: input imag byte 0x80 (0x8011), CONJ_SAT=1 -> mirrored bin 0x7F11; CONJ_SAT=0 -> 0x8011.
- Backpressure: random dout_ready with about 50% duty -> same 16-sample sequence; dout stable while dout_valid=1 and dout_ready=0.
- Input gaps and blocking: din_valid toggling -> only handshaked samples stored. din_valid held in EMIT -> din_ready=0 and output unchanged.
- Flush: flush after 4 inputs -> next burst of 6 new inputs produces output from the new data only. Flush mid-EMIT at sample 5 -> dout_valid=0 next cycle, din_ready=1.
- Back-to-back bursts plus rst: two bursts sent consecutively -> din_ready returns 1 cycle after burst_last. rst asserted mid-EMIT -> all outputs return to reset values next edge.
